// File: rtl/lstm_gate_preact_seq.sv
// Sequential LSTM gate pre-activation engine: A = Wx'x + Wh'h_prev + b, computed LANES
// columns per pass from 1-cycle-latency read ports, emitted on a valid/ready stream.
module lstm_gate_preact_seq #(
  parameter int N_IN  = 100,
  parameter int N_OUT = 400,
  parameter int W     = 32,
  parameter int LANES = 4,
  parameter int ACC_W = 80,
  parameter int SAT   = 0,
  localparam int NG   = N_OUT / LANES,
  localparam int RW   = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int GW   = (NG > 1) ? $clog2(NG) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [RW-1:0]      rd_row,
  output logic [GW-1:0]      rd_grp,
  input  logic [W-1:0]       x_rd_data,
  input  logic [W-1:0]       h_rd_data,
  input  logic [LANES*W-1:0] wx_rd_data,
  input  logic [LANES*W-1:0] wh_rd_data,
  output logic               b_rd_en,
  input  logic [LANES*W-1:0] b_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [GW-1:0]      out_grp,
  output logic [LANES*W-1:0] out_data
);

  if (N_OUT % LANES != 0) begin : g_lanes_chk
    $error("N_OUT must be a multiple of LANES");
  end

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [RW-1:0]           r_k;
  logic [GW-1:0]           r_g;
  logic                    r_done;
  logic                    r_vld_p1;
  logic                    r_bvld_p1;
  logic signed [ACC_W-1:0] r_acc_p1 [LANES];
  logic signed [ACC_W-1:0] w_acc_p1 [LANES];
  logic signed [ACC_W-1:0] w_bias_p1 [LANES];
  logic signed [2*W-1:0]   w_px_p1 [LANES];
  logic signed [2*W-1:0]   w_ph_p1 [LANES];
  logic signed [2*W-1:0]   w_xe_p1;
  logic signed [2*W-1:0]   w_he_p1;
  logic [LANES*W-1:0]      r_out_p2;
  logic [GW-1:0]           r_grp_p2;
  logic                    w_last_k;
  logic                    w_last_g;
  logic                    w_xfer;

  assign w_last_k = (r_k == RW'(N_IN - 1));
  assign w_last_g = (r_g == GW'(NG - 1));
  assign w_xfer   = (r_state == S_OUT) && out_ready;

  // Out-of-range accumulators have upper bits (from bit W-1 up) that are not all equal.
  function automatic logic [W-1:0] conv_out(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-W:0] top;
    top = a[ACC_W-1:W-1];
    if (SAT == 0 || top == '0 || top == '1) return a[W-1:0];
    else if (a[ACC_W-1])                    return {1'b1, {(W-1){1'b0}}};
    else                                    return {1'b0, {(W-1){1'b1}}};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_BIAS;
      S_BIAS:  w_next = S_MAC;
      S_MAC:   if (w_last_k) w_next = S_DRAIN;
      S_DRAIN: w_next = S_OUT;
      S_OUT:   if (out_ready) w_next = w_last_g ? S_IDLE : S_BIAS;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    rd_en     = (r_state == S_MAC);
    b_rd_en   = (r_state == S_BIAS);
    out_valid = (r_state == S_OUT);
    rd_row    = (r_state == S_MAC) ? r_k : '0;
    rd_grp    = (r_state == S_MAC || r_state == S_BIAS) ? r_g : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_g    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last_g;
      case (r_state)
        S_IDLE:  if (start) r_g <= '0;
        S_BIAS:  r_k <= '0;
        S_MAC:   if (!w_last_k) r_k <= r_k + 1'b1;
        S_OUT:   if (out_ready) r_g <= w_last_g ? '0 : r_g + 1'b1;
        default: ;
      endcase
    end
  end

  // p1: read data returns one cycle after its strobe; the valids follow it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_bvld_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= (r_state == S_MAC);
      r_bvld_p1 <= (r_state == S_BIAS);
    end
  end

  always_comb begin
    w_xe_p1 = {{W{x_rd_data[W-1]}}, x_rd_data};
    w_he_p1 = {{W{h_rd_data[W-1]}}, h_rd_data};
    for (int i = 0; i < LANES; i++) begin
      w_px_p1[i]   = {{W{wx_rd_data[i*W+W-1]}}, wx_rd_data[i*W +: W]} * w_xe_p1;
      w_ph_p1[i]   = {{W{wh_rd_data[i*W+W-1]}}, wh_rd_data[i*W +: W]} * w_he_p1;
      w_acc_p1[i]  = r_acc_p1[i] + ACC_W'(w_px_p1[i]) + ACC_W'(w_ph_p1[i]);
      w_bias_p1[i] = {{(ACC_W-W){b_rd_data[i*W+W-1]}}, b_rd_data[i*W +: W]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) r_acc_p1[i] <= '0;
    end else if (r_bvld_p1) begin
      for (int i = 0; i < LANES; i++) r_acc_p1[i] <= w_bias_p1[i];
    end else if (r_vld_p1) begin
      for (int i = 0; i < LANES; i++) r_acc_p1[i] <= w_acc_p1[i];
    end
  end

  // p2: DRAIN folds in the last row and converts straight into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_p2 <= '0;
      r_grp_p2 <= '0;
    end else if (r_state == S_DRAIN) begin
      for (int i = 0; i < LANES; i++) r_out_p2[i*W +: W] <= conv_out(w_acc_p1[i]);
      r_grp_p2 <= r_g;
    end
  end

  assign out_data = r_out_p2;
  assign out_grp  = r_grp_p2;
  assign done     = r_done;

endmodule

// File: tb/tb_lstm_gate_preact_seq.sv
// Bench for lstm_gate_preact_seq: two small instances (wrap/saturate) on a vector table,
// plus the default 100x400 configuration against a golden model.
module tb_lstm_gate_preact_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- small configuration: N_IN=2, N_OUT=4, LANES=2 ----------------
  logic        start_s = 1'b0;
  logic        rdy_s   = 1'b1;
  logic        a_busy, a_done, a_rd_en, a_b_rd_en, a_ov;
  logic        b_busy, b_done, b_rd_en_r, b_b_rd_en, b_ov;
  logic [0:0]  a_rd_row, a_rd_grp, a_og, b_rd_row, b_rd_grp, b_og;
  logic [63:0] a_od, b_od;
  logic [31:0] x_rd_s, h_rd_s;
  logic [63:0] wx_rd_s, wh_rd_s, b_rd_s;

  lstm_gate_preact_seq #(.N_IN(2), .N_OUT(4), .W(32), .LANES(2), .ACC_W(80), .SAT(0)) u_a (
    .clk(clk), .rst(rst), .start(start_s), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_row(a_rd_row), .rd_grp(a_rd_grp),
    .x_rd_data(x_rd_s), .h_rd_data(h_rd_s), .wx_rd_data(wx_rd_s), .wh_rd_data(wh_rd_s),
    .b_rd_en(a_b_rd_en), .b_rd_data(b_rd_s),
    .out_valid(a_ov), .out_ready(rdy_s), .out_grp(a_og), .out_data(a_od));

  lstm_gate_preact_seq #(.N_IN(2), .N_OUT(4), .W(32), .LANES(2), .ACC_W(80), .SAT(1)) u_b (
    .clk(clk), .rst(rst), .start(start_s), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en_r), .rd_row(b_rd_row), .rd_grp(b_rd_grp),
    .x_rd_data(x_rd_s), .h_rd_data(h_rd_s), .wx_rd_data(wx_rd_s), .wh_rd_data(wh_rd_s),
    .b_rd_en(b_b_rd_en), .b_rd_data(b_rd_s),
    .out_valid(b_ov), .out_ready(rdy_s), .out_grp(b_og), .out_data(b_od));

  typedef struct packed {
    logic [1:0][31:0] x;
    logic [1:0][31:0] h;
    logic [31:0]      wx;
    logic [31:0]      wh;
    logic [3:0][31:0] b;
    logic [3:0][31:0] ea;
    logic [3:0][31:0] es;
  } vec_t;
  vec_t vt [5];

  logic [1:0][31:0] xs, hs;
  logic [31:0]      wxv, whv;
  logic [3:0][31:0] bs;

  always @(posedge clk) begin
    if (a_rd_en) begin
      x_rd_s  <= xs[a_rd_row];
      h_rd_s  <= hs[a_rd_row];
      wx_rd_s <= {wxv, wxv};
      wh_rd_s <= {whv, whv};
    end
    if (a_b_rd_en) b_rd_s <= {bs[{a_rd_grp, 1'b1}], bs[{a_rd_grp, 1'b0}]};
  end

  typedef struct packed {
    logic [7:0]   g;
    logic [127:0] d;
  } sb_t;
  sb_t qa[$], qb[$], qc[$];

  always @(negedge clk) begin : mon_small
    sb_t e;
    if (!rst && a_ov && rdy_s) begin
      if (qa.size() == 0) chk("a_sb_empty", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_grp", a_og, e.g);
        chk("a_data", a_od, e.d);
      end
    end
    if (!rst && b_ov && rdy_s) begin
      if (qb.size() == 0) chk("b_sb_empty", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_grp", b_og, e.g);
        chk("b_data", b_od, e.d);
      end
    end
  end

  task automatic load_small(input int v);
    xs  = vt[v].x;
    hs  = vt[v].h;
    wxv = vt[v].wx;
    whv = vt[v].wh;
    bs  = vt[v].b;
    qa.push_back('{g: 8'd0, d: {64'd0, vt[v].ea[1:0]}});
    qa.push_back('{g: 8'd1, d: {64'd0, vt[v].ea[3:2]}});
    qb.push_back('{g: 8'd0, d: {64'd0, vt[v].es[1:0]}});
    qb.push_back('{g: 8'd1, d: {64'd0, vt[v].es[3:2]}});
  endtask

  task automatic small_go(input int v, input bit busy_pulse, input bit chain_in, input bit chain_out);
    int s, t_ov, t_done;
    load_small(v);
    if (!chain_in) begin
      @(posedge clk); #1;
      start_s = 1'b1;
    end
    s      = cyc;
    t_ov   = -1;
    t_done = -1;
    for (int c = 0; c < 40 && t_done < 0; c++) begin
      @(posedge clk); #1;
      start_s = 1'b0;
      if (cyc == s + 1) chk($sformatf("v%0d_bias_at_S1", v), {a_b_rd_en, a_busy}, 2'b11);
      if (busy_pulse && cyc == s + 3) start_s = 1'b1;
      if (a_ov && t_ov < 0) t_ov = cyc - s;
      if (a_done) begin
        t_done = cyc - s;
        if (chain_out) start_s = 1'b1;
      end
    end
    chk($sformatf("v%0d_first_valid", v), t_ov, 5);
    chk($sformatf("v%0d_done_time", v), t_done, 11);
  endtask

  task automatic backpressure();
    int s, t_ov, t_done;
    load_small(0);
    rdy_s = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b1;
    s       = cyc;
    t_ov    = -1;
    t_done  = -1;
    for (int c = 0; c < 20 && t_ov < 0; c++) begin
      @(posedge clk); #1;
      start_s = 1'b0;
      if (a_ov) t_ov = cyc - s;
    end
    chk("bp_first_valid", t_ov, 5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk("bp_hold", {a_ov, a_rd_en, a_b_rd_en, a_og, a_od}, {1'b1, 1'b0, 1'b0, 1'b0, vt[0].ea[1:0]});
    end
    @(posedge clk); #1;
    chk("bp_hold_last", {a_ov, a_b_rd_en, a_og}, 3'b100);
    rdy_s = 1'b1;
    @(posedge clk); #1;
    chk("bp_bias_after_xfer", {a_b_rd_en, a_rd_grp}, 2'b11);
    for (int c = 0; c < 20 && t_done < 0; c++) begin
      if (a_done) t_done = cyc - s;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("bp_done_time", t_done, 16);
  endtask

  // ---------------- default configuration: 100 x 400, LANES=4 ----------------
  logic         start_c = 1'b0;
  logic         rdy_c   = 1'b1;
  logic         c_busy, c_done, c_rd_en, c_b_rd_en, c_ov;
  logic [6:0]   c_rd_row, c_rd_grp, c_og;
  logic [127:0] c_od;
  logic [31:0]  x_rd_c, h_rd_c;
  logic [127:0] wx_rd_c, wh_rd_c, b_rd_c;

  lstm_gate_preact_seq u_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(c_busy), .done(c_done),
    .rd_en(c_rd_en), .rd_row(c_rd_row), .rd_grp(c_rd_grp),
    .x_rd_data(x_rd_c), .h_rd_data(h_rd_c), .wx_rd_data(wx_rd_c), .wh_rd_data(wh_rd_c),
    .b_rd_en(c_b_rd_en), .b_rd_data(b_rd_c),
    .out_valid(c_ov), .out_ready(rdy_c), .out_grp(c_og), .out_data(c_od));

  logic [31:0] xc [100];
  logic [31:0] hc [100];
  logic [31:0] bc [400];
  logic [31:0] wxc [100][400];
  logic [31:0] whc [100][400];

  always @(posedge clk) begin
    if (c_rd_en) begin
      x_rd_c <= xc[c_rd_row];
      h_rd_c <= hc[c_rd_row];
      for (int i = 0; i < 4; i++) begin
        wx_rd_c[i*32 +: 32] <= wxc[c_rd_row][int'(c_rd_grp)*4+i];
        wh_rd_c[i*32 +: 32] <= whc[c_rd_row][int'(c_rd_grp)*4+i];
      end
    end
    if (c_b_rd_en)
      for (int i = 0; i < 4; i++) b_rd_c[i*32 +: 32] <= bc[int'(c_rd_grp)*4+i];
  end

  always @(negedge clk) begin : mon_c
    sb_t e;
    if (!rst && c_ov && rdy_c) begin
      if (qc.size() == 0) chk("c_sb_empty", 1, 0);
      else begin
        e = qc.pop_front();
        chk("c_grp", c_og, e.g);
        for (int i = 0; i < 4; i++)
          chk($sformatf("c_col%0d", int'(e.g)*4+i), c_od[i*32 +: 32], e.d[i*32 +: 32]);
      end
    end
  end

  // Random operands; wrapped reference kept in 32-bit two's complement.
  task automatic load_c();
    int          acc;
    logic [127:0] d;
    int          expc [400];
    for (int k = 0; k < 100; k++) begin
      xc[k] = $urandom();
      hc[k] = $urandom();
      for (int c = 0; c < 400; c++) begin
        wxc[k][c] = $urandom();
        whc[k][c] = $urandom();
      end
    end
    for (int c = 0; c < 400; c++) begin
      bc[c] = $urandom();
      acc   = int'(bc[c]);
      for (int k = 0; k < 100; k++)
        acc += int'(wxc[k][c]) * int'(xc[k]) + int'(whc[k][c]) * int'(hc[k]);
      expc[c] = acc;
    end
    for (int g = 0; g < 100; g++) begin
      for (int i = 0; i < 4; i++) d[i*32 +: 32] = expc[g*4+i];
      qc.push_back('{g: 8'(g), d: d});
    end
  endtask

  task automatic run_c(input bit rnd);
    int s, t_done;
    load_c();
    @(posedge clk); #1;
    start_c = 1'b1;
    s       = cyc;
    t_done  = -1;
    for (int c = 0; c < 40000 && t_done < 0; c++) begin
      @(posedge clk); #1;
      start_c = 1'b0;
      if (rnd) rdy_c = 1'($urandom_range(0, 1));
      if (c_done) t_done = cyc - s;
    end
    rdy_c = 1'b1;
    if (!rnd) chk("c_done_time", t_done, 10301);
    else      chk("c_done_seen", t_done > 0, 1);
    chk("c_sb_drained", qc.size(), 0);
  endtask

  task automatic abort_c();
    bit found;
    load_c();
    @(posedge clk); #1;
    start_c = 1'b1;
    found   = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk); #1;
      start_c = 1'b0;
      if (c_rd_en && c_rd_grp == 7'd1 && c_rd_row == 7'd37) found = 1'b1;
    end
    chk("abort_reached_g1_k37", found, 1);
    rst = 1'b1;
    #1;
    chk("abort_ctrl_zero", {c_busy, c_done, c_rd_en, c_b_rd_en, c_ov, c_rd_row, c_rd_grp, c_og}, 0);
    chk("abort_data_zero", c_od, 0);
    qc.delete();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0].x = {32'd2, 32'd1};
    vt[0].h = {32'd4, 32'd3};
    vt[0].wx = 32'd1;
    vt[0].wh = 32'd2;
    vt[0].b  = {32'd40, 32'd30, 32'd20, 32'd10};
    vt[0].ea = {32'd57, 32'd47, 32'd37, 32'd27};
    vt[0].es = {32'd57, 32'd47, 32'd37, 32'd27};

    vt[1].x = {32'h7FFFFFFF, 32'h7FFFFFFF};
    vt[1].h = '0;
    vt[1].wx = 32'd1;
    vt[1].wh = 32'd5;
    vt[1].b  = '0;
    vt[1].ea = {4{32'hFFFFFFFE}};
    vt[1].es = {4{32'h7FFFFFFF}};

    vt[2].x = {32'h80000000, 32'h80000000};
    vt[2].h = '0;
    vt[2].wx = 32'd1;
    vt[2].wh = 32'd0;
    vt[2].b  = '0;
    vt[2].ea = '0;
    vt[2].es = {4{32'h80000000}};

    vt[3].x = {32'd5, 32'hFFFFFFFD};
    vt[3].h = {32'hFFFFFFF9, 32'd2};
    vt[3].wx = 32'hFFFFFFFC;
    vt[3].wh = 32'd3;
    vt[3].b  = {32'd1, 32'd0, 32'hFFFFFF9C, 32'd100};
    vt[3].ea = {32'hFFFFFFEA, 32'hFFFFFFE9, 32'hFFFFFF85, 32'd77};
    vt[3].es = {32'hFFFFFFEA, 32'hFFFFFFE9, 32'hFFFFFF85, 32'd77};

    vt[4].x = {32'h40000000, 32'h40000000};
    vt[4].h = '0;
    vt[4].wx = 32'd4;
    vt[4].wh = 32'd0;
    vt[4].b  = {32'd4, 32'd3, 32'd2, 32'd1};
    vt[4].ea = {32'd4, 32'd3, 32'd2, 32'd1};
    vt[4].es = {4{32'h7FFFFFFF}};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_small_ctrl", {a_busy, a_done, a_rd_en, a_b_rd_en, a_ov, a_rd_row, a_rd_grp, a_og}, 0);
    chk("reset_small_data", a_od, 0);
    chk("reset_sat_data", {b_busy, b_ov, b_od}, 0);
    chk("reset_c_ctrl", {c_busy, c_done, c_rd_en, c_b_rd_en, c_ov, c_rd_row, c_rd_grp, c_og}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++)
      small_go(v, v == 1, v == 3, v == 2);
    backpressure();
    chk("small_sb_drained", {qa.size(), qb.size()}, 0);

    run_c(1'b0);
    abort_c();
    run_c(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
